// File: rtl/sub_serial_nibble.sv
// Nibble-serial subtractor: diff = a - b - borrow_in, one 4-bit slice per clock, LSB first.
// A single operation is in flight at a time, with valid/ready handshakes on both sides.
module sub_serial_nibble #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_nb_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;
    logic [WIDTH-1:0] w_diff_next;

    // Current nibble of a + ~b + carry through a 4-bit generate/propagate chain
    always_comb begin
        w_a_nib  = r_a[{r_cnt, 2'b00} +: 4];
        w_nb_nib = ~r_b[{r_cnt, 2'b00} +: 4];
        w_g      = w_a_nib & w_nb_nib;
        w_p      = w_a_nib ^ w_nb_nib;
        w_c      = 5'b00000;
        w_c[0]   = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        w_sum       = w_p ^ w_c[3:0];
        w_diff_next = r_diff;
        w_diff_next[{r_cnt, 2'b00} +: 4] = w_sum;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, operand capture, nibble accumulation and final flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_diff   <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ~borrow_in;
                        r_cnt   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_c[4];
                    r_cnt   <= r_cnt + 1'b1;
                    // Flags are taken from the completed result on the final nibble edge
                    if (r_cnt == LAST) begin
                        r_borrow <= ~w_c[4];
                        r_zero   <= (w_diff_next == {WIDTH{1'b0}});
                        r_neg    <= w_diff_next[WIDTH-1];
                        r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &
                                    (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE) & ~rst;
    assign out_valid  = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign zero       = r_zero;
    assign negative   = r_neg;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_sub_serial_nibble.sv
// Scoreboard bench for sub_serial_nibble: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_sub_serial_nibble;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;
    logic         negative;
    logic         overflow;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    sub_serial_nibble #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain wide unsigned and signed arithmetic
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t e;
        logic [W:0] full;
        int sx;
        int sy;
        int sd;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        sd   = sx - sy - int'(bi);
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.z  = (full[W-1:0] == '0);
        e.n  = full[W-1];
        e.v  = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever a result is handed over
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("diff",       {16'd0, diff},       {16'd0, e.d});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
                chk("zero",       {31'd0, zero},       {31'd0, e.z});
                chk("negative",   {31'd0, negative},   {31'd0, e.n});
                chk("overflow",   {31'd0, overflow},   {31'd0, e.v});
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi,
                         input int hold);
        int cnt;
        logic [W-1:0] held_d;
        logic [3:0]   held_f;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        a = ta; b = tb_v; borrow_in = tbi; in_valid = 1'b1;
        sb_q.push_back(model(ta, tb_v, tbi));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        borrow_in = 1'($urandom_range(0, 1));
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 32'd4);
        if (hold > 0) begin
            held_d = diff;
            held_f = {borrow_out, zero, negative, overflow};
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000;
                @(posedge clk); #1;
                chk("hold_valid",    {31'd0, out_valid}, 32'd1);
                chk("hold_diff",     {16'd0, diff}, {16'd0, held_d});
                chk("hold_flags",    {28'd0, borrow_out, zero, negative, overflow}, {28'd0, held_f});
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      {16'd0, diff}, 32'd0);
        chk("rst_flags",     {28'd0, borrow_out, zero, negative, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        do_op(16'h1234, 16'h0234, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        do_op(16'h5555, 16'h5555, 1'b0, 0);
        do_op(16'h5555, 16'h5555, 1'b1, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        do_op(16'h1234, 16'h0234, 1'b0, 3);
        do_op(16'h00F0, 16'h000F, 1'b0, 0);

        // Reset during the second RUN cycle discards the operation
        a = 16'h4321; b = 16'h1111; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_diff",      {16'd0, diff}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release", {31'd0, in_ready}, 32'd1);
        do_op(16'h0010, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end
        do_op(16'h8000, 16'h8000, 1'b1, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 2);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
